ps2_mouse_tx_ctrl: RTL and testbench
====================================

# ps2_mouse_tx_ctrl

Host-to-device transmit controller for the PS/2 mouse port. It sequences the open-drain PS/2 clock and data lines to send one command byte to the mouse: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, and device acknowledge. It uses the existing `ps2_mouse_watchdog` as its time base. It clears that watchdog at phase boundaries and consumes its 150 µs and 400 µs terminal flags. It sits between the mouse command logic and the PS/2 pad drivers, alongside the receive path.

## Interface
Parameters:
- None. Frame format is fixed at 8 data bits + odd parity + stop.

Ports:
- `clk`  in  1  system clock; the same clock as the watchdog.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  one-cycle request; accepted only in IDLE.
- `tx_data`  in  8  byte to send; captured on an accepted `tx_start`.
- `falling_edge`  in  1  one-cycle strobe from the synchronized PS/2 clock edge detector.
- `ps2_data_in`  in  1  synchronized PS/2 data line level.
- `timer_150us_done`  in  1  watchdog 150 µs flag.
- `timer_400us_done`  in  1  watchdog timeout flag.
- `wd_clear`  out  1  one-cycle clear to the watchdog; OR'd into the watchdog's reset term.
- `ps2_clk_oe`  out  1  1 = pull the PS/2 clock low.
- `ps2_data_oe`  out  1  1 = pull the PS/2 data low.
- `tx_busy`  out  1  high from acceptance until the terminating pulse.
- `tx_done`  out  1  one-cycle pulse: frame acknowledged.
- `tx_error`  out  1  one-cycle pulse: timeout or NACK.

## Operation
- The byte is latched into a shift register. Odd parity is computed at capture: parity = ~^tx_data.
- IDLE: all outputs 0. On `tx_start`:
  - latch the byte;
  - pulse `wd_clear`;
  - go to INHIBIT.
- INHIBIT:
  - `ps2_clk_oe`=1 and `tx_busy`=1.
  - `falling_edge` is ignored, because the host's own pulldown creates one.
  - On `timer_150us_done`: pulse `wd_clear`, go to START.
- START:
  - `ps2_clk_oe`=0; `ps2_data_oe`=1, which is the start bit.
  - Wait for a device `falling_edge`.
- SEND:
  - Bit counter runs 0..10 and increments on each `falling_edge`.
  - After edges 1–8: `ps2_data_oe` = ~data[edge-1].
  - After edge 9: `ps2_data_oe` = ~parity.
  - After edge 10: `ps2_data_oe`=0, releasing the line for the stop bit.
  - Edge 11 is the ACK edge. Sample `ps2_data_in`:
    - 0 → `tx_done`;
    - 1 → `tx_error` (NACK).
  - Then return to IDLE.
- Timeout: in START or SEND, `timer_400us_done` → pulse `tx_error`, release both lines, go to IDLE.
- `tx_start` while `tx_busy` is ignored. The latched byte is unchanged.

## Timing
- Reset (`reset`=0): immediately go to IDLE with every output 0 (`wd_clear`, `ps2_clk_oe`, `ps2_data_oe`, `tx_busy`, `tx_done`, `tx_error`). This applies mid-frame: the lines are released asynchronously.
- `tx_start` at cycle n: at n+1, `tx_busy`=1, `ps2_clk_oe`=1 and `wd_clear`=1 (for 1 cycle).
- `timer_150us_done` at cycle m: at m+1, `ps2_clk_oe`=0, `ps2_data_oe`=1 and `wd_clear`=1.
- `falling_edge` at cycle k: the new `ps2_data_oe` value is registered at k+1.
- On the 11th edge at cycle k, at k+1:
  - `tx_done` or `tx_error` is 1;
  - `tx_busy`=0 and both OEs are 0.
- A new `tx_start` is accepted at k+1.
- `falling_edge` and `timer_400us_done` in the same cycle: the edge wins and no error is raised. The watchdog self-clears on that edge.
- `tx_done` and `tx_error` are never high together. Each is exactly 1 cycle.

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined: the ACK sample is checked. `ps2_data_in`=1 at edge 11 produces `tx_error`.
- Undefined: the ACK value is ignored. Edge 11 always produces `tx_done`; only a timeout produces `tx_error`.

## Test plan
- Send 0xF4 with the device clocking and ACK low:
  - `ps2_data_oe` after edges 1–10 = 1,1,0,1,0,0,0,0,1,0;
  - `tx_done`=1 for 1 cycle after edge 11.
- Send 0xFF: the parity slot (after edge 9) gives `ps2_data_oe`=0 (parity=1).
- Stop the device clock after edge 4 and raise `timer_400us_done`:
  - `tx_error` pulse, both OEs 0, `tx_busy`=0 the next cycle.
- ACK high at edge 11:
  - with `PS2_TX_ACK_CHECK_EN` → `tx_error`;
  - without it → `tx_done`.
- Pulse `tx_start` with 0x00 during SEND of 0xF4: frame bits are unchanged and only one `tx_done` is produced.
- Assert `reset`=0 during INHIBIT: `ps2_clk_oe` is 0 in the same cycle. After release, IDLE accepts a new `tx_start`.

Source files
------------

// File: rtl/ps2_mouse_tx_ctrl.sv
// PS/2 host-to-device byte transmitter: inhibit, start, 8 data LSB-first, odd parity, stop, ACK; PS2_TX_ACK_CHECK_EN enables the ACK check.
// Latency: every output is registered one cycle after the qualifying input (tx_start, 150us flag, falling edge, timeout).
// Backpressure: tx_start is dropped while tx_busy; the device paces the frame through its own clock edges.
module ps2_mouse_tx_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       falling_edge,
    input  logic       ps2_data_in,
    input  logic       timer_150us_done,
    input  logic       timer_400us_done,
    output logic       wd_clear,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SEND
    } state_t;

    state_t     state;
    logic [8:0] shift_q;
    logic [3:0] bit_cnt;
    logic       ack_ok;

`ifdef PS2_TX_ACK_CHECK_EN
    assign ack_ok = ~ps2_data_in;
`else
    logic unused_ack;
    assign unused_ack = ps2_data_in;
    assign ack_ok     = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shift_q     <= 9'h1ff;
            bit_cnt     <= 4'd0;
            wd_clear    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            wd_clear <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        shift_q    <= {~^tx_data, tx_data};
                        bit_cnt    <= 4'd0;
                        wd_clear   <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        tx_busy    <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    // our own clock pulldown produces an edge here, so edges are ignored
                    if (timer_150us_done) begin
                        wd_clear    <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START, ST_SEND: begin
                    if (falling_edge) begin
                        if (bit_cnt == 4'd10) begin
                            tx_done     <= ack_ok;
                            tx_error    <= ~ack_ok;
                            tx_busy     <= 1'b0;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            // ones shifted in behind parity make the stop slot release the line
                            ps2_data_oe <= ~shift_q[0];
                            shift_q     <= {1'b1, shift_q[8:1]};
                            bit_cnt     <= bit_cnt + 4'd1;
                            state       <= ST_SEND;
                        end
                    end else if (timer_400us_done) begin
                        tx_error    <= 1'b1;
                        tx_busy     <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    tx_busy     <= 1'b0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_mouse_tx_ctrl.sv
// Randomized scoreboard bench for ps2_mouse_tx_ctrl: stimulus pushes expected events, a monitor pops them on DUT activity.
module tb_ps2_mouse_tx_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       falling_edge = 1'b0;
    logic       ps2_data_in = 1'b1;
    logic       timer_150us_done = 1'b0;
    logic       timer_400us_done = 1'b0;
    logic       wd_clear, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;

    ps2_mouse_tx_ctrl dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .falling_edge(falling_edge), .ps2_data_in(ps2_data_in),
        .timer_150us_done(timer_150us_done), .timer_400us_done(timer_400us_done),
        .wd_clear(wd_clear), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_EDGE = 2'd0, K_WD = 2'd1, K_END = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       clk_oe;
        logic       data_oe;
        logic       busy;
        logic       done;
        logic       err;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    function automatic ev_t mk(input logic [1:0] k, input logic c, input logic d,
                               input logic b, input logic dn, input logic er);
        ev_t e;
        e.kind = k; e.clk_oe = c; e.data_oe = d; e.busy = b; e.done = dn; e.err = er;
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples just after each active edge, pops one expectation per DUT event.
    initial begin
        ev_t obs;
        ev_t want;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) continue;
            if (tx_done || tx_error || wd_clear || falling_edge) begin
                obs.kind    = (tx_done || tx_error) ? K_END : (wd_clear ? K_WD : K_EDGE);
                obs.clk_oe  = ps2_clk_oe;
                obs.data_oe = ps2_data_oe;
                obs.busy    = tx_busy;
                obs.done    = tx_done;
                obs.err     = tx_error;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %b with nothing expected at %0t", obs, $time);
                end else begin
                    want = exp_q.pop_front();
                    check("event", {1'b0, obs}, {1'b0, want});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One transaction: n_edges device edges (11 = full frame); fewer ends in a timeout.
    task automatic send_frame(input logic [7:0] b, input int n_edges, input logic ack_lvl,
                              input logic inject, input int race_edge, input logic inhibit_edge);
        logic [9:0] line;
        int         ones;
        logic       ack_good;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            line[i] = b[i];
            ones += int'(b[i]);
        end
        line[8] = (ones % 2 == 0);
        line[9] = 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
        ack_good = (ack_lvl == 1'b0);
`else
        ack_good = 1'b1;
`endif
        exp_q.push_back(mk(K_WD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        tx_start = 1'b1; tx_data = b;
        cyc();
        tx_start = 1'b0; tx_data = 8'($urandom);
        repeat ($urandom_range(1, 4)) cyc();
        if (inhibit_edge) begin
            exp_q.push_back(mk(K_EDGE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
            falling_edge = 1'b1;
            cyc();
            falling_edge = 1'b0;
        end
        exp_q.push_back(mk(K_WD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        timer_150us_done = 1'b1;
        cyc();
        timer_150us_done = 1'b0;
        for (int e = 1; e <= n_edges; e++) begin
            repeat ($urandom_range(1, 4)) cyc();
            if (e == 11) begin
                ps2_data_in = ack_lvl;
                exp_q.push_back(mk(K_END, 1'b0, 1'b0, 1'b0, ack_good, ~ack_good));
            end else begin
                ps2_data_in = 1'($urandom);
                exp_q.push_back(mk(K_EDGE, 1'b0, ~line[e-1], 1'b1, 1'b0, 1'b0));
            end
            timer_400us_done = (e == race_edge);
            falling_edge = 1'b1;
            cyc();
            falling_edge = 1'b0;
            timer_400us_done = 1'b0;
            ps2_data_in = 1'b1;
            if (inject && e == 5) begin
                tx_start = 1'b1; tx_data = 8'h00;
                cyc();
                tx_start = 1'b0;
            end
        end
        if (n_edges < 11) begin
            repeat ($urandom_range(1, 5)) cyc();
            exp_q.push_back(mk(K_END, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            timer_400us_done = 1'b1;
            cyc();
            timer_400us_done = 1'b0;
        end
    endtask

    initial begin
        #12;
        check("reset_outputs", {2'b0, wd_clear, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 8'h00);
        cyc();
        reset = 1'b1;
        repeat (2) cyc();

        send_frame(8'hF4, 11, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'hFF, 11, 1'b0, 1'b0, 0, 1'b1);
        send_frame(8'hA5, 4, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'h3C, 11, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'hF4, 11, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h5A, 11, 1'b0, 1'b0, 7, 1'b0);

        // Reset in the middle of clock inhibit must release the clock line at once.
        exp_q.push_back(mk(K_WD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        tx_start = 1'b1; tx_data = 8'h81;
        cyc();
        tx_start = 1'b0;
        cyc();
        check("inhibit_clk_oe_before_reset", {7'b0, ps2_clk_oe}, 8'h01);
        reset = 1'b0;
        #1;
        check("reset_mid_inhibit", {2'b0, wd_clear, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 8'h00);
        check("queue_empty_at_reset", 8'(exp_q.size()), 8'd0);
        exp_q.delete();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        send_frame(8'hE6, 11, 1'b0, 1'b0, 0, 1'b0);

        for (int f = 0; f < 25; f++) begin
            int   ne;
            int   race;
            ne = ($urandom_range(0, 9) < 7) ? 11 : int'($urandom_range(0, 10));
            race = ($urandom_range(0, 3) == 0 && ne > 0) ? int'($urandom_range(1, (ne > 10) ? 10 : ne)) : 0;
            send_frame(8'($urandom), ne, 1'($urandom), (ne >= 6) ? 1'($urandom) : 1'b0,
                       race, 1'($urandom));
        end

        repeat (5) cyc();
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
